// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, status-word flag positions
// and the single-bit adder cells used by the carry-chain slices.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;

    typedef struct packed {
        logic z;
        logic v;
        logic c;
    } alu_flags_t;

    // Returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry slice; also exposes the carry into its MSB
// so the final slice can derive signed overflow.
module adder_slice
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb_in
);

    logic [W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < W; i++) begin
            {carry[i+1], sum[i]} = full_add(a[i], b[i], carry[i]);
        end
    end

    assign c_out    = carry[W];
    assign c_msb_in = carry[W-1];

endmodule

// File: rtl/adder_pipelined.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES
// registered slices with a valid/ready handshake and per-stage backpressure.
module adder_pipelined
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("adder_pipelined: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Subtraction is a + ~b + 1; the carry-in port is ignored in that mode.
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub | c_in;

    // rdy[k]: stage k may load this cycle (it is empty or its content moves on).
    logic [STAGES:0] rdy;
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * SLICE;

        logic             src_vld;
        logic             src_cy;
        logic [REM-1:0]   rem_a;
        logic [REM-1:0]   rem_b;
        logic [WIDTH-1:0] src_res;
        logic [WIDTH-1:0] nxt_res;
        logic [SLICE-1:0] s_sum;
        logic             s_cout;
        logic             s_cmsb;
        logic             vld_q;
        logic             cy_q;
        logic [WIDTH-1:0] res_q;

        if (k == 0) begin : g_src
            assign src_vld = in_valid;
            assign src_cy  = c_eff;
            assign rem_a   = a;
            assign rem_b   = b_eff;
            assign src_res = '0;
        end else begin : g_src
            assign src_vld = g_stage[k-1].vld_q;
            assign src_cy  = g_stage[k-1].cy_q;
            assign rem_a   = g_stage[k-1].g_ops.opa_q;
            assign rem_b   = g_stage[k-1].g_ops.opb_q;
            assign src_res = g_stage[k-1].res_q;
        end

        adder_slice #(.W(SLICE)) u_slice (
            .a        (rem_a[SLICE-1:0]),
            .b        (rem_b[SLICE-1:0]),
            .c_in     (src_cy),
            .sum      (s_sum),
            .c_out    (s_cout),
            .c_msb_in (s_cmsb)
        );

        always_comb begin
            nxt_res = src_res;
            nxt_res[k*SLICE +: SLICE] = s_sum;
        end

        assign rdy[k] = ~vld_q | rdy[k+1];

        // Data only moves with a real operation so idle X inputs never reach the outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                res_q <= '0;
            end else if (rdy[k]) begin
                vld_q <= src_vld;
                if (src_vld) begin
                    cy_q  <= s_cout;
                    res_q <= nxt_res;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            // Only the still-unprocessed upper operand bits travel onward.
            logic [REM-SLICE-1:0] opa_q;
            logic [REM-SLICE-1:0] opb_q;
            logic                 cmsb_unused;
            assign cmsb_unused = s_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (rdy[k] && src_vld) begin
                    opa_q <= rem_a[REM-1:SLICE];
                    opb_q <= rem_b[REM-1:SLICE];
                end
            end
        end else begin : g_flags
            logic zero_q;
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    zero_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (rdy[k] && src_vld) begin
                    zero_q <= (nxt_res == '0);
                    ovf_q  <= s_cmsb ^ s_cout;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].res_q;
    assign c_out     = g_stage[STAGES-1].cy_q;
    assign overflow  = g_stage[STAGES-1].g_flags.ovf_q;
    assign zero      = g_stage[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_adder_pipelined.sv
// Bench for adder_pipelined: a 4-stage and a 1-stage 64-bit instance checked
// against an arithmetic reference model with randomized handshakes.
module tb_adder_pipelined;

    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = 66'sh3_8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv4, ir4, cin4, sub4, ov4, or4, c4, v4, z4;
    logic [63:0] a4, b4, s4;
    logic        iv1, ir1, cin1, sub1, ov1, or1, c1, v1, z1;
    logic [63:0] a1, b1, s1;

    int checks = 0;
    int errors = 0;

    adder_pipelined #(.WIDTH(64), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .c_in(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4),
        .c_out(c4), .overflow(v4), .zero(z4)
    );

    adder_pipelined #(.WIDTH(64), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .c_in(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(s1),
        .c_out(c1), .overflow(v1), .zero(z1)
    );

    // Reference: {zero, overflow, c_out, sum} from plain integer arithmetic.
    function automatic logic [66:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb);
        logic [64:0]        u;
        logic signed [65:0] s;
        logic               c, v;
        if (sb) begin
            u = {1'b0, x} - {1'b0, y};
            c = (x >= y);
            s = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
        end else begin
            u = {1'b0, x} + {1'b0, y} + {64'd0, ci};
            c = u[64];
            s = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, ci});
        end
        v = (s > SMAX) || (s < SMIN);
        return {(u[63:0] == 64'd0), v, c, u[63:0]};
    endfunction

    task automatic gen_op(output logic [63:0] x, output logic [63:0] y,
                          output logic ci, output logic sb);
        x  = {$urandom, $urandom};
        y  = {$urandom, $urandom};
        ci = 1'($urandom_range(1));
        sb = 1'($urandom_range(1));
        case ($urandom_range(7))
            0: y = x;
            1: x = 64'h7FFF_FFFF_FFFF_FFFF;
            2: y = ~x;
            default: ;
        endcase
    endtask

    task automatic idle_inputs();
        iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; or4 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; or1 = 1'b1;
    endtask

    // One op through the 4-stage instance; lat counts rising edges until out_valid.
    task automatic run_single4(input logic [63:0] x, input logic [63:0] y, input logic ci,
                               input logic sb, output logic [66:0] obs, output int lat);
        @(negedge clk);
        iv4 = 1'b1; a4 = x; b4 = y; cin4 = ci; sub4 = sb; or4 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            iv4 = 1'b0;
            #1;
            lat++;
        end while (!ov4 && lat < 20);
        obs = {z4, v4, c4, s4};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv4 = 1'b1; a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom}; or4 = 1'b1;
        iv1 = 1'b1; a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; or1 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ov4, z4, v4, c4, s4} !== 68'd0)
            $display("FAIL reset_out4: got %h required 0", {ov4, z4, v4, c4, s4});
        checks++;
        if ({ov1, z1, v1, c1, s1} !== 68'd0)
            $display("FAIL reset_out1: got %h required 0", {ov1, z1, v1, c1, s1});
        checks++;
        if ({ir4, ir1} !== 2'b11)
            $display("FAIL reset_in_ready: got %b required 11", {ir4, ir1});
        errors += int'({ov4, z4, v4, c4, s4} !== 68'd0) + int'({ov1, z1, v1, c1, s1} !== 68'd0)
                + int'({ir4, ir1} !== 2'b11);
        @(negedge clk);
        iv4 = 1'b0; a4 = 'x; b4 = 'x; cin4 = 1'bx; sub4 = 1'bx;
        iv1 = 1'b0; a1 = 'x; b1 = 'x; cin1 = 1'bx; sub1 = 1'bx;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            checks++;
            if ({ov4, z4, v4, c4, s4, ov1, z1, v1, c1, s1} !== 136'd0) begin
                errors++;
                $display("FAIL reset_release_idle: got %h / %h required 0",
                         {ov4, z4, v4, c4, s4}, {ov1, z1, v1, c1, s1});
            end
        end
        idle_inputs();
    endtask

    task automatic test_directed();
        logic [66:0] obs;
        int          lat;
        logic [66:0] req [5];
        logic [63:0] xa  [5];
        logic [63:0] xb  [5];
        logic        ci  [5];
        logic        sb  [5];
        xa[0] = 64'hFFFF_FFFF_FFFF_FFFF; xb[0] = 64'd1; ci[0] = 0; sb[0] = 0;
        req[0] = {1'b1, 1'b0, 1'b1, 64'h0};
        xa[1] = 64'h7FFF_FFFF_FFFF_FFFF; xb[1] = 64'd1; ci[1] = 0; sb[1] = 0;
        req[1] = {1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000};
        xa[2] = 64'd5; xb[2] = 64'd7; ci[2] = 0; sb[2] = 1;
        req[2] = {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        xa[3] = 64'd5; xb[3] = 64'd5; ci[3] = 1; sb[3] = 1;
        req[3] = {1'b1, 1'b0, 1'b1, 64'h0};
        xa[4] = 64'h0000_0000_FFFF_FFFF; xb[4] = 64'h0000_0000_0000_0002; ci[4] = 1; sb[4] = 0;
        req[4] = {1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0002};
        for (int i = 0; i < 5; i++) begin
            run_single4(xa[i], xb[i], ci[i], sb[i], obs, lat);
            checks++;
            if (obs !== req[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %h required %h", i, obs, req[i]);
            end
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL latency_%0d: got %0d required 4", i, lat);
            end
        end
        idle_inputs();
    endtask

    // Random stream into the 4-stage instance with scoreboard and handshake checks.
    task automatic stream4(input int n_ops, input int vpct, input bit rand_ready,
                           input int st0, input int stlen, output int max_out,
                           output bit saw_block);
        logic [66:0] q[$];
        logic [66:0] pend, exp;
        logic [63:0] x, y, prev_sum;
        logic        ci, sb, have, prev_hold;
        int          sent, got, cyc, outstanding;
        sent = 0; got = 0; cyc = 0; have = 0; prev_hold = 0; prev_sum = '0;
        pend = '0; max_out = 0; saw_block = 0;
        while (got < n_ops && cyc < n_ops * 20 + 50) begin
            @(negedge clk);
            if (!have && sent < n_ops && $urandom_range(99) < vpct) begin
                gen_op(x, y, ci, sb);
                a4 = x; b4 = y; cin4 = ci; sub4 = sb;
                pend = model(x, y, ci, sb);
                have = 1'b1;
            end
            iv4 = have;
            or4 = rand_ready ? 1'($urandom_range(1)) : !(cyc >= st0 && cyc < st0 + stlen);
            #1;
            outstanding = sent - got;
            if (outstanding > max_out) max_out = outstanding;
            checks++;
            if (ir4 !== (or4 || outstanding < 4)) begin
                errors++;
                $display("FAIL in_ready: got %b required %b (in flight %0d)", ir4,
                         (or4 || outstanding < 4), outstanding);
            end
            if (prev_hold) begin
                checks++;
                if (ov4 !== 1'b1 || s4 !== prev_sum) begin
                    errors++;
                    $display("FAIL stall_hold: got %b/%h required 1/%h", ov4, s4, prev_sum);
                end
            end
            if (ov4 && or4) begin
                exp = (q.size() != 0) ? q.pop_front() : 'x;
                checks++;
                if ({z4, v4, c4, s4} !== exp) begin
                    errors++;
                    $display("FAIL stream_result_%0d: got %h required %h", got, {z4, v4, c4, s4}, exp);
                end
                got++;
            end
            if (have && ir4) begin
                q.push_back(pend);
                sent++;
                have = 1'b0;
            end
            if (iv4 && !ir4) saw_block = 1'b1;
            prev_hold = ov4 && !or4;
            prev_sum  = s4;
            cyc++;
        end
        checks++;
        if (got != n_ops) begin
            errors++;
            $display("FAIL stream_count: got %0d results required %0d", got, n_ops);
        end
        iv4 = 1'b0; or4 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            checks++;
            if (ov4 !== 1'b0) begin
                errors++;
                $display("FAIL stream_extra_output: got out_valid %b required 0", ov4);
            end
        end
    endtask

    task automatic test_backpressure();
        int mo;
        bit blk;
        stream4(8, 100, 1'b0, 4, 6, mo, blk);
        checks++;
        if (!blk) begin
            errors++;
            $display("FAIL bp_in_ready_drop: got never-low required low during stall");
        end
        checks++;
        if (mo != 4) begin
            errors++;
            $display("FAIL bp_queue_depth: got %0d required 4", mo);
        end
    endtask

    task automatic test_bubbles();
        int mo;
        bit blk;
        stream4(60, 50, 1'b1, 0, 0, mo, blk);
    endtask

    task automatic test_midflight_reset();
        logic [66:0] obs;
        int          lat;
        @(negedge clk);
        or4 = 1'b0; or1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv4 = 1'b1; a4 = {$urandom, $urandom}; b4 = 64'd1;
            iv1 = 1'b1; a1 = {$urandom, $urandom}; b1 = 64'd1;
            @(negedge clk);
        end
        iv4 = 1'b0; iv1 = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov4, s4, ov1, s1} !== 130'd0) begin
            errors++;
            $display("FAIL midflight_reset: got %b/%h %b/%h required 0", ov4, s4, ov1, s1);
        end
        @(negedge clk);
        rst_n = 1'b1; or4 = 1'b1; or1 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            checks++;
            if ({ov4, ov1} !== 2'b00) begin
                errors++;
                $display("FAIL midflight_ghost: got %b required 00", {ov4, ov1});
            end
        end
        run_single4(64'd3, 64'd4, 1'b0, 1'b0, obs, lat);
        checks++;
        if (obs !== {3'b000, 64'd7} || lat != 4) begin
            errors++;
            $display("FAIL after_reset_op: got %h lat %0d required %h lat 4", obs, lat, {3'b000, 64'd7});
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back(input bit one);
        logic [66:0] q[$];
        logic [66:0] exp, obs;
        logic [63:0] x, y;
        logic        ci, sb, ovx, irx;
        int          lat, got;
        lat = one ? 1 : 4;
        got = 0;
        for (int i = 0; i < 100 + lat; i++) begin
            @(negedge clk);
            gen_op(x, y, ci, sb);
            if (one) begin
                iv1 = (i < 100); a1 = x; b1 = y; cin1 = ci; sub1 = sb; or1 = 1'b1;
            end else begin
                iv4 = (i < 100); a4 = x; b4 = y; cin4 = ci; sub4 = sb; or4 = 1'b1;
            end
            #1;
            ovx = one ? ov1 : ov4;
            irx = one ? ir1 : ir4;
            obs = one ? {z1, v1, c1, s1} : {z4, v4, c4, s4};
            checks++;
            if (irx !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready_s%0d: got %b required 1", lat, irx);
            end
            checks++;
            if (ovx !== (i >= lat)) begin
                errors++;
                $display("FAIL b2b_out_valid_s%0d cycle %0d: got %b required %b", lat, i, ovx, (i >= lat));
            end
            if (ovx) begin
                exp = (q.size() != 0) ? q.pop_front() : 'x;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL b2b_result_s%0d_%0d: got %h required %h", lat, got, obs, exp);
                end
                got++;
            end
            if (i < 100) q.push_back(model(x, y, ci, sb));
        end
        checks++;
        if (got != 100) begin
            errors++;
            $display("FAIL b2b_count_s%0d: got %0d required 100", lat, got);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_directed();
        test_backpressure();
        test_bubbles();
        test_midflight_reset();
        test_back_to_back(1'b1);
        test_back_to_back(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
